// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall controller and the datapath that
// consumes its enable/flush bundle.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } stall_state_t;

    typedef struct packed {
        logic pc_enable;
        logic fd_enable;
        logic fd_flush;
        logic de_enable;
        logic de_flush;
        logic em_enable;
        logic mw_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t PIPE_CTRL_RUN = '{
        pc_enable: 1'b1, fd_enable: 1'b1, fd_flush: 1'b0,
        de_enable: 1'b1, de_flush: 1'b0, em_enable: 1'b1, mw_flush: 1'b0
    };

endpackage

// File: rtl/load_use_detector.sv
// Flags a decode instruction that reads the destination of a load in execute.
module load_use_detector #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] d_rs1,
    input  logic [REG_ADDR_W-1:0] d_rs2,
    input  logic                  d_uses_rs1,
    input  logic                  d_uses_rs2,
    input  logic [REG_ADDR_W-1:0] e_rd,
    input  logic                  e_mem_read,
    output logic                  hazard
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit = d_uses_rs1 && (d_rs1 == e_rd);
        rs2_hit = d_uses_rs2 && (d_rs2 == e_rd);
        // x0 is hard-wired, so a load to it never produces a usable value
        hazard  = e_mem_read && (e_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Drives the PC and pipeline-register enables/flushes for load-use hazards,
// taken branches and multi-cycle data-memory accesses with a timeout.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = pipeline_ctrl_pkg::REG_ADDR_W,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] d_rs1,
    input  logic [REG_ADDR_W-1:0] d_rs2,
    input  logic                  d_uses_rs1,
    input  logic                  d_uses_rs2,
    input  logic [REG_ADDR_W-1:0] e_rd,
    input  logic                  e_mem_read,
    input  logic                  e_pc_src,
    input  logic                  m_mem_access,
    input  logic                  dmem_ready,
    output logic                  dmem_valid,
    output logic                  pc_enable,
    output logic                  fd_enable,
    output logic                  fd_flush,
    output logic                  de_enable,
    output logic                  de_flush,
    output logic                  em_enable,
    output logic                  mw_flush,
    output logic                  bus_error,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    stall_state_t      state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              bus_error_q, bus_error_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic       hazard;
    logic       active;
    logic       mem_stall;
    logic       lu_stall;
    logic       branch;
    pipe_ctrl_t ctrl;

    load_use_detector #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_load_use (
        .d_rs1      (d_rs1),
        .d_rs2      (d_rs2),
        .d_uses_rs1 (d_uses_rs1),
        .d_uses_rs2 (d_uses_rs2),
        .e_rd       (e_rd),
        .e_mem_read (e_mem_read),
        .hazard     (hazard)
    );

    always_comb begin
        active     = !reset && (state_q != ERROR);
        dmem_valid = active && m_mem_access;
        mem_stall  = dmem_valid && !dmem_ready;
        branch     = active && !mem_stall && e_pc_src;
        // A taken branch squashes the dependent instruction anyway, so it
        // overrides the load-use bubble and that cycle is not a stall.
        lu_stall   = active && !mem_stall && !e_pc_src && hazard;

        ctrl = PIPE_CTRL_RUN;
        if (!reset && (state_q == ERROR)) begin
            ctrl.pc_enable = 1'b0;
            ctrl.fd_enable = 1'b0;
            ctrl.de_enable = 1'b0;
            ctrl.em_enable = 1'b0;
        end else if (mem_stall) begin
            ctrl.pc_enable = 1'b0;
            ctrl.fd_enable = 1'b0;
            ctrl.de_enable = 1'b0;
            ctrl.em_enable = 1'b0;
            ctrl.mw_flush  = 1'b1;
        end else if (branch) begin
            ctrl.fd_flush  = 1'b1;
            ctrl.de_flush  = 1'b1;
        end else if (lu_stall) begin
            ctrl.pc_enable = 1'b0;
            ctrl.fd_enable = 1'b0;
            ctrl.de_flush  = 1'b1;
        end
    end

    assign pc_enable   = ctrl.pc_enable;
    assign fd_enable   = ctrl.fd_enable;
    assign fd_flush    = ctrl.fd_flush;
    assign de_enable   = ctrl.de_enable;
    assign de_flush    = ctrl.de_flush;
    assign em_enable   = ctrl.em_enable;
    assign mw_flush    = ctrl.mw_flush;
    assign bus_error   = bus_error_q;
    assign stall_count = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        bus_error_d = bus_error_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wait_d  = '0;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d = RUN;
                end else if (wait_q == WAIT_LAST) begin
                    state_d     = ERROR;
                    bus_error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = RUN;
        endcase

        if ((mem_stall || lu_stall) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_q      <= '0;
            bus_error_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            bus_error_q <= bus_error_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
